// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART transmitter: sends a 14-byte frame 0x55, 11 payload bytes, CRC-8 (0x07), 0xAA.
// Payload is captured when the request is accepted, so later input changes never reach the line.
module uart_mult_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       send_req,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  input  logic [7:0] tx_data3,
  input  logic [7:0] tx_data4,
  input  logic [7:0] tx_data5,
  input  logic [7:0] tx_data6,
  input  logic [7:0] tx_data7,
  input  logic [7:0] tx_data8,
  input  logic [7:0] tx_data9,
  input  logic [7:0] tx_data10,
  output logic       uart_txd,
  output logic       busy,
  output logic       send_done,
  output logic [3:0] byte_cnt,
  output logic [7:0] crc8_value
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int DATA_NUM = 14;
  localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(DATA_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_reg, state_next;
  logic [15:0] clk_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [3:0]  byte_cnt_reg;
  logic [7:0]  crc_reg;
  logic [7:0]  payload_reg [11];
  logic [7:0]  tx_data_arr [11];
  logic        txd_reg, busy_reg, done_reg;
  logic        txd_next, busy_next, done_next;
  logic        accept, bit_end, last_byte;
  logic [7:0]  cur_byte;

  assign tx_data_arr[0]  = tx_data0;
  assign tx_data_arr[1]  = tx_data1;
  assign tx_data_arr[2]  = tx_data2;
  assign tx_data_arr[3]  = tx_data3;
  assign tx_data_arr[4]  = tx_data4;
  assign tx_data_arr[5]  = tx_data5;
  assign tx_data_arr[6]  = tx_data6;
  assign tx_data_arr[7]  = tx_data7;
  assign tx_data_arr[8]  = tx_data8;
  assign tx_data_arr[9]  = tx_data9;
  assign tx_data_arr[10] = tx_data10;

  assign accept    = (state_reg == IDLE) && send_req;
  assign bit_end   = (clk_cnt_reg == BIT_LAST);
  assign last_byte = (byte_cnt_reg == LAST_BYTE);

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Byte currently selected for the line, chosen by its position in the frame.
  always_comb begin
    cur_byte = 8'h55;
    if (byte_cnt_reg == 4'd12) begin
      cur_byte = crc_reg;
    end else if (byte_cnt_reg == 4'd13) begin
      cur_byte = 8'hAA;
    end else if (byte_cnt_reg != 4'd0 && byte_cnt_reg <= 4'd11) begin
      cur_byte = payload_reg[byte_cnt_reg - 4'd1];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (send_req) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_cnt_reg == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = last_byte ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Next line level is decided one edge ahead so uart_txd stays a plain flop.
  always_comb begin
    txd_next  = txd_reg;
    busy_next = busy_reg;
    done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (send_req) begin
          txd_next  = 1'b0;
          busy_next = 1'b1;
        end else begin
          txd_next = 1'b1;
        end
      end
      START: if (bit_end) txd_next = cur_byte[0];
      DATA: begin
        if (bit_end) begin
          txd_next = (bit_cnt_reg == 3'd7) ? 1'b1 : cur_byte[bit_cnt_reg + 3'd1];
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            txd_next  = 1'b1;
            busy_next = 1'b0;
            done_next = 1'b1;
          end else begin
            txd_next = 1'b0;
          end
        end
      end
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      txd_reg  <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      txd_reg  <= txd_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt_reg  <= 16'd0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 4'd0;
      crc_reg      <= 8'h00;
      for (int i = 0; i < 11; i++) begin
        payload_reg[i] <= 8'h00;
      end
    end else begin
      if (state_reg == IDLE || bit_end) begin
        clk_cnt_reg <= 16'd0;
      end else begin
        clk_cnt_reg <= clk_cnt_reg + 16'd1;
      end

      if (state_reg != DATA) begin
        bit_cnt_reg <= 3'd0;
      end else if (bit_end) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      if (accept) begin
        byte_cnt_reg <= 4'd0;
        crc_reg      <= 8'h00;
        for (int i = 0; i < 11; i++) begin
          payload_reg[i] <= tx_data_arr[i];
        end
      end else if (state_reg == STOP && bit_end) begin
        byte_cnt_reg <= last_byte ? 4'd0 : byte_cnt_reg + 4'd1;
        // Fold each payload byte in as it becomes the byte on the line.
        if (byte_cnt_reg <= 4'd10) begin
          crc_reg <= crc8_next(crc_reg, payload_reg[byte_cnt_reg]);
        end
      end
    end
  end

  assign uart_txd   = txd_reg;
  assign busy       = busy_reg;
  assign send_done  = done_reg;
  assign byte_cnt   = byte_cnt_reg;
  assign crc8_value = crc_reg;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx at 10 clocks per bit (1400-clock frames).
// Frames are decoded mid-bit relative to the accepting edge and compared against a CRC-8 model.
module tb_uart_mult_byte_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int FRAME    = 1400;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] tx_d [11];
  logic       uart_txd, busy, send_done;
  logic [3:0] byte_cnt;
  logic [7:0] crc8_value;

  int checks = 0;
  int passed = 0;

  logic [7:0] pay [11];
  logic [7:0] next_pay [11];
  logic [7:0] cap_bytes [14];
  int         cap_busy, cap_done, cap_done_at, cap_ferr, cap_bc5;
  logic       cap_idle_txd;

  always #5 sys_clk = ~sys_clk;

  uart_mult_byte_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .send_req(send_req),
    .tx_data0(tx_d[0]), .tx_data1(tx_d[1]), .tx_data2(tx_d[2]), .tx_data3(tx_d[3]),
    .tx_data4(tx_d[4]), .tx_data5(tx_d[5]), .tx_data6(tx_d[6]), .tx_data7(tx_d[7]),
    .tx_data8(tx_d[8]), .tx_data9(tx_d[9]), .tx_data10(tx_d[10]),
    .uart_txd(uart_txd), .busy(busy), .send_done(send_done),
    .byte_cnt(byte_cnt), .crc8_value(crc8_value)
  );

  // Bit-serial CRC-8, poly 0x07, MSB first, over the current payload.
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int b = 0; b < 11; b++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ pay[b][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input int b);
    if (b == 0) return 8'h55;
    if (b <= 11) return pay[b-1];
    if (b == 12) return model_crc();
    return 8'hAA;
  endfunction

  task automatic start_frame();
    @(negedge sys_clk);
    for (int i = 0; i < 11; i++) tx_d[i] = pay[i];
    send_req = 1'b1;
    @(posedge sys_clk);
  endtask

  // Watches one frame from the accepting edge; k counts negedges after that edge.
  task automatic capture(input bit drop_req, input int poke_k, input bit poke_req);
    cap_busy = 0; cap_done = 0; cap_done_at = -1; cap_ferr = 0; cap_bc5 = -1;
    cap_idle_txd = 1'b0;
    for (int b = 0; b < 14; b++) cap_bytes[b] = 8'h00;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge sys_clk);
      if (k == 0 && drop_req) send_req = 1'b0;
      if (k == poke_k) begin
        for (int i = 0; i < 11; i++) tx_d[i] = next_pay[i];
        if (poke_req) send_req = 1'b1;
      end
      if (k == poke_k + 1 && poke_req) send_req = 1'b0;
      if (busy) cap_busy++;
      if (send_done) begin
        cap_done++;
        cap_done_at = k;
      end
      if (k == 550) cap_bc5 = int'(byte_cnt);
      if (k < FRAME && k % 10 == 5) begin
        int bi, by, pos;
        bi = k / 10; by = bi / 10; pos = bi % 10;
        if (pos == 0 && uart_txd !== 1'b0) cap_ferr++;
        else if (pos == 9 && uart_txd !== 1'b1) cap_ferr++;
        else if (pos >= 1 && pos <= 8) cap_bytes[by][pos-1] = uart_txd;
      end
      if (k == FRAME) cap_idle_txd = uart_txd;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (uart_txd !== 1'b1) $display("FAIL reset_txd got=%b want=1", uart_txd); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    checks++; if (send_done !== 1'b0) $display("FAIL reset_done got=%b want=0", send_done); else passed++;
    checks++; if (byte_cnt !== 4'd0) $display("FAIL reset_byte_cnt got=%0d want=0", byte_cnt); else passed++;
    checks++; if (crc8_value !== 8'h00) $display("FAIL reset_crc got=%h want=00", crc8_value); else passed++;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (uart_txd !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset txd=%b busy=%b want 1/0", uart_txd, busy); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_zero_payload();
    for (int i = 0; i < 11; i++) pay[i] = 8'h00;
    start_frame();
    capture(1, -10, 0);
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL zero_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (cap_ferr !== 0) $display("FAIL zero_framing got=%0d errors want=0", cap_ferr); else passed++;
    checks++; if (cap_done !== 1 || cap_done_at !== FRAME) $display("FAIL zero_done pulses=%0d at=%0d want 1 at %0d", cap_done, cap_done_at, FRAME); else passed++;
    checks++; if (cap_busy !== FRAME) $display("FAIL zero_busy got=%0d want=%0d", cap_busy, FRAME); else passed++;
    checks++; if (crc8_value !== 8'h00) $display("FAIL zero_crc got=%h want=00", crc8_value); else passed++;
    checks++; if (cap_bc5 !== 5) $display("FAIL zero_byte_cnt got=%0d want=5", cap_bc5); else passed++;
    $display("test_zero_payload done");
  endtask

  task automatic test_crc_payload();
    for (int i = 0; i < 11; i++) pay[i] = 8'(i + 1);
    start_frame();
    capture(1, -10, 0);
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL crc_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (cap_ferr !== 0) $display("FAIL crc_framing got=%0d errors want=0", cap_ferr); else passed++;
    checks++; if (cap_done !== 1 || cap_done_at !== FRAME) $display("FAIL crc_done pulses=%0d at=%0d want 1 at %0d", cap_done, cap_done_at, FRAME); else passed++;
    repeat (20) @(negedge sys_clk);
    checks++; if (crc8_value !== model_crc()) $display("FAIL crc_hold got=%h want=%h", crc8_value, model_crc()); else passed++;
    $display("test_crc_payload done");
  endtask

  task automatic test_ignore_midframe();
    int extra_done, extra_busy;
    for (int i = 0; i < 11; i++) begin
      pay[i] = 8'hA0 + 8'(i * 3);
      next_pay[i] = 8'hFF;
    end
    start_frame();
    capture(1, 520, 1);
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL mid_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (cap_done !== 1 || cap_done_at !== FRAME) $display("FAIL mid_done pulses=%0d at=%0d want 1 at %0d", cap_done, cap_done_at, FRAME); else passed++;
    extra_done = 0; extra_busy = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (send_done) extra_done++;
      if (busy || uart_txd !== 1'b1) extra_busy++;
    end
    checks++; if (extra_done !== 0 || extra_busy !== 0) $display("FAIL mid_no_second_frame done=%0d active=%0d want 0/0", extra_done, extra_busy); else passed++;
    $display("test_ignore_midframe done");
  endtask

  task automatic test_back_to_back();
    logic first_idle;
    int   first_done_at;
    for (int i = 0; i < 11; i++) begin
      pay[i] = 8'h3C ^ 8'(i * 17);
      next_pay[i] = 8'hC5 + 8'(i * 29);
    end
    start_frame();
    capture(0, 300, 0);
    first_idle = cap_idle_txd;
    first_done_at = cap_done_at;
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL b2b1_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (first_idle !== 1'b1 || first_done_at !== FRAME) $display("FAIL b2b_gap idle_txd=%b done_at=%0d want 1/%0d", first_idle, first_done_at, FRAME); else passed++;
    for (int i = 0; i < 11; i++) pay[i] = next_pay[i];
    @(posedge sys_clk);
    capture(1, -10, 0);
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL b2b2_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (cap_ferr !== 0 || cap_busy !== FRAME) $display("FAIL b2b2_timing ferr=%0d busy=%0d want 0/%0d", cap_ferr, cap_busy, FRAME); else passed++;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_abort();
    int bad;
    for (int i = 0; i < 11; i++) pay[i] = 8'h5A + 8'(i);
    pay[6] = 8'h00;
    start_frame();
    for (int k = 0; k <= 740; k++) begin
      @(negedge sys_clk);
      if (k == 0) send_req = 1'b0;
    end
    checks++; if (uart_txd !== 1'b0 || byte_cnt !== 4'd7) $display("FAIL abort_pre txd=%b byte_cnt=%0d want 0/7", uart_txd, byte_cnt); else passed++;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) $display("FAIL abort_async_txd got=%b want=1", uart_txd); else passed++;
    checks++; if (busy !== 1'b0 || byte_cnt !== 4'd0 || crc8_value !== 8'h00) $display("FAIL abort_state busy=%b byte_cnt=%0d crc=%h want 0/0/00", busy, byte_cnt, crc8_value); else passed++;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sys_clk);
      if (k == 5) sys_rst_n = 1'b1;
      if (send_done || busy || uart_txd !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL abort_quiet got=%0d active cycles want=0", bad); else passed++;
    pay[6] = 8'h77;
    start_frame();
    capture(1, -10, 0);
    for (int b = 0; b < 14; b++) begin
      checks++;
      if (cap_bytes[b] !== exp_byte(b)) $display("FAIL abort_next_byte%0d got=%h want=%h", b, cap_bytes[b], exp_byte(b)); else passed++;
    end
    checks++; if (cap_done !== 1 || cap_done_at !== FRAME || cap_ferr !== 0) $display("FAIL abort_next_done pulses=%0d at=%0d ferr=%0d", cap_done, cap_done_at, cap_ferr); else passed++;
    $display("test_reset_abort done");
  endtask

  initial begin
    for (int i = 0; i < 11; i++) begin
      tx_d[i] = 8'h00;
      pay[i] = 8'h00;
      next_pay[i] = 8'h00;
    end
    test_reset();
    test_zero_payload();
    test_crc_payload();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_mult_byte_tx.md
UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, serial bit rate.
REQ-003 SHALL have localparam BPS_CNT = CLK_FREQ/UART_BPS (integer division; 434 at defaults), clocks per serial bit.
REQ-004 SHALL have localparam DATA_NUM = 14, bytes per frame.
REQ-005 SHALL have port sys_clk, input, 1, the single clock; every flop is rising-edge.
REQ-006 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port send_req, input, 1, frame-send request, sampled every cycle.
REQ-008 SHALL have ports tx_data0..tx_data10, input, 8 each, payload bytes 1..11 of the frame.
REQ-009 SHALL have port uart_txd, output, 1, serial line; idle high.
REQ-010 SHALL have port busy, output, 1, high while a frame is in flight.
REQ-011 SHALL have port send_done, output, 1, one-cycle pulse when a frame completes.
REQ-012 SHALL have port byte_cnt, output, 4, index of the byte currently on the line (0..13).
REQ-013 SHALL have port crc8_value, output, 8, running CRC of the payload bytes loaded so far.

Function
REQ-014 SHALL send frame byte order: 0x55, tx_data0..tx_data10, CRC8, 0xAA (14 bytes).
REQ-015 SHALL compute CRC8 with polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, over the 11 payload bytes only.
REQ-016 SHALL send each byte as 10 bits, LSB first: start bit (0), 8 data bits, stop bit (1); each bit lasts exactly BPS_CNT clocks.
REQ-017 SHALL start the next byte's start bit in the cycle after the previous stop bit ends; no inter-byte gap. Frame length is 14*10*BPS_CNT clocks (60760 at defaults).
REQ-018 SHALL implement the FSM states IDLE, START, DATA, STOP. IDLE->START on accepted request; START->DATA after BPS_CNT clocks; DATA->STOP after 8 bits; STOP->START if byte_cnt<13, else STOP->IDLE.
REQ-019 SHALL accept a request when send_req=1 in IDLE at a rising edge, latching tx_data0..10 into internal registers at that edge and clearing the CRC to 0x00.
REQ-020 SHALL drive uart_txd low for the start bit of byte 0 from the clock edge that accepts the request; busy SHALL go high at the same edge.
REQ-021 SHALL not let input changes after acceptance affect the frame in flight.
REQ-022 SHALL ignore send_req while busy=1; requests are not queued.
REQ-023 SHALL update the CRC when each payload byte (byte_cnt 1..11) is loaded for transmission, so that byte 12 transmits the final CRC; crc8_value SHALL hold after the frame until the next acceptance.
REQ-024 SHALL pulse send_done high for exactly one cycle at the edge where the stop bit of byte 13 ends, and busy SHALL fall at that same edge.
REQ-025 SHALL allow a send_req held high or re-asserted in the send_done cycle to be accepted on the next edge; minimum frame-to-frame spacing is one idle clock.
REQ-026 SHALL size the bit clock counter at 16 bits; it wraps to 0 at BPS_CNT-1.
REQ-027 SHALL register uart_txd; no combinational path from inputs to uart_txd.

Reset
REQ-028 SHALL set, while sys_rst_n=0: uart_txd=1, busy=0, send_done=0, byte_cnt=0, crc8_value=0x00, FSM=IDLE, counters=0, latched payload=0.
REQ-029 SHALL abort a frame if reset is asserted mid-frame; uart_txd SHALL go high immediately without waiting for a clock, and no send_done SHALL be produced.
REQ-030 SHALL accept a request no earlier than the first rising edge after sys_rst_n deasserts.

Verification
REQ-031 SHALL cover: payload all 0x00, one send_req pulse -> line decodes 55 00x11 00 AA; send_done once, 60760 clocks after acceptance; busy high for exactly that span.
REQ-032 SHALL cover: payload 0x01,0x02..0x0B -> byte 12 equals the bench CRC-8/0x07 model; the existing receiver (CLK_FREQ/UART_BPS matched) loops back with recv_done=1 and rev_data0..10 = 0x01..0x0B.
REQ-033 SHALL cover: send_req pulsed again at byte_cnt=5 and tx_data changed mid-frame -> frame unchanged, only one send_done, no second frame.
REQ-034 SHALL cover: send_req held high continuously -> back-to-back frames separated by exactly one idle-high clock, each with correct CRC.
REQ-035 SHALL cover: sys_rst_n pulled low during the DATA state of byte 7 -> uart_txd=1 asynchronously, busy=0, no send_done; the next request sends a complete, correct frame.
REQ-036 SHALL cover: CLK_FREQ=1_000_000, UART_BPS=100_000 -> each bit is exactly 10 clocks, frame 1400 clocks.
